instruction_fetch_sequencer: RTL and testbench
==============================================

// Module: instruction_fetch_sequencer
// PURPOSE
//  Fetches one 16-bit instruction as two bytes from byte-wide memory and feeds them to the
//  instruction register. It owns the PC and drives the register's I/Write/LH inputs. Sits
//  between memory and the instruction register; it is started by the control unit and
//  reports completion back to it.
// PARAMETERS
//  ADDR_W    16  PC / memory address width
//  RESET_PC  0   PC value after reset
//  TIMEOUT   15  max cycles to wait for MemValid per byte (>=1); WaitCnt is clog2(TIMEOUT+1) bits
// PORTS
//  Clock     in   1       single clock; all state changes on posedge
//  Reset     in   1       synchronous, active-low reset
//  FetchReq  in   1       start a fetch; sampled only in IDLE
//  PCLoad    in   1       load PC from PCIn; honoured only in IDLE
//  PCIn      in   ADDR_W  jump target
//  MemData   in   8       read data from memory
//  MemValid  in   1       MemData valid for the current MemAddr
//  MemRead   out  1       memory read request
//  MemAddr   out  ADDR_W  byte address (= PC)
//  IRData    out  8       byte to instruction register I input (= MemData pass-through)
//  IRWrite   out  1       instruction register Write
//  IRLH      out  1       0 = low byte [7:0], 1 = high byte [15:8]
//  PC        out  ADDR_W  current program counter
//  Busy      out  1       high in any state other than IDLE
//  FetchDone out  1       one-cycle pulse: instruction fully loaded
//  FetchErr  out  1       one-cycle pulse: memory timeout, fetch aborted
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): state=IDLE, PC=RESET_PC, StartPC=RESET_PC, WaitCnt=0.
//    All strobes (MemRead, IRWrite, FetchDone, FetchErr) are 0 and Busy=0. A reset
//    mid-fetch aborts silently: no FetchDone, no FetchErr.
//  - States: IDLE -> FETCH_LO -> FETCH_HI -> DONE -> IDLE. A timeout in either FETCH
//    state goes to ERR -> IDLE.
//  - IDLE:
//    - PCLoad=1: PC<=PCIn.
//    - FetchReq=1: StartPC<=(PCLoad ? PCIn : PC), WaitCnt<=0, go to FETCH_LO.
//    - PCLoad and FetchReq together: the fetch uses PCIn.
//  - FETCH_LO / FETCH_HI:
//    - MemRead=1 and MemAddr=PC, held stable until MemValid.
//    - IRWrite=MemValid and IRData=MemData, combinational, so the instruction register
//      captures the byte on the same edge. IRLH=0 in FETCH_LO, 1 in FETCH_HI.
//    - On MemValid: PC<=PC+1 (mod 2^ADDR_W, so all-ones wraps to 0), WaitCnt<=0,
//      advance to the next state.
//    - Else WaitCnt<=WaitCnt+1. When WaitCnt==TIMEOUT-1 with no MemValid:
//      PC<=StartPC, go to ERR.
//  - DONE: FetchDone=1 for exactly this cycle, Busy=1, then IDLE.
//  - ERR: FetchErr=1 for exactly this cycle, Busy=1, then IDLE. The PC is already
//    restored to StartPC (the PC after any FETCH_LO increment is discarded), so a
//    retry refetches the same instruction.
//  - In FETCH_LO, FETCH_HI, DONE and ERR, FetchReq and PCLoad are ignored (no queueing).
//  - Byte order: byte at StartPC goes to IR[7:0]; byte at StartPC+1 goes to IR[15:8].
//  - Latency with zero-wait memory (MemValid=1 whenever MemRead=1): FetchReq seen at
//    edge 0; FETCH_LO in cycle 1, FETCH_HI in cycle 2, FetchDone in cycle 3. Back-to-back
//    fetches therefore take 4 cycles each. Each memory wait cycle adds 1 cycle.
//  - Outside FETCH states: MemRead=0 and IRWrite=0. IRLH=0 and IRData=MemData there (don't-care).
// TESTING
//  1 Reset, zero-wait mem, mem[0]=0x34, mem[1]=0x12, FetchReq pulse -> IRWrite in cycles 1 (LH=0)
//    and 2 (LH=1), FetchDone at cycle 3, IR=0x1234, PC=2.
//  2 PCLoad=1, PCIn=0x00FF, FetchReq=1 same cycle, mem[0xFF]=0xCD, mem[0x100]=0xAB ->
//    MemAddr 0x00FF then 0x0100, IR=0xABCD, PC=0x0101.
//  3 PC=0xFFFF, mem[0xFFFF]=0x78, mem[0]=0x56 -> MemAddr 0xFFFF then 0x0000, IR=0x5678, PC=0x0001.
//  4 MemValid delayed 3 cycles per byte -> MemAddr stable while waiting, IRWrite only on valid
//    cycles, FetchDone 9 cycles after the FetchReq edge.
//  5 TIMEOUT=4, low byte valid, high byte never valid -> FetchErr pulse, no FetchDone,
//    PC back to StartPC. Retry with a responsive memory completes normally.
//  6 Reset low during FETCH_HI -> next cycle IDLE, PC=RESET_PC, no FetchDone or FetchErr.
//    FetchReq/PCLoad pulsed during FETCH_LO -> ignored, PC unchanged by PCLoad.

Source files
------------

// File: rtl/instruction_fetch_sequencer.sv
// Fetches a 16-bit instruction as two bytes (low byte first) from byte-wide memory into the IR.
// Owns the PC. A timeout on either byte restores the PC to the start of the instruction.
module instruction_fetch_sequencer #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              FetchReq,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCIn,
  input  logic [7:0]        MemData,
  input  logic              MemValid,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        IRData,
  output logic              IRWrite,
  output logic              IRLH,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              FetchDone,
  output logic              FetchErr
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      start_pc_q <= RESET_PC;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      start_pc_q <= start_pc_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    start_pc_d = start_pc_q;
    wait_cnt_d = wait_cnt_q;
    MemRead    = 1'b0;
    IRWrite    = 1'b0;
    IRLH       = 1'b0;
    Busy       = 1'b1;
    FetchDone  = 1'b0;
    FetchErr   = 1'b0;

    case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (PCLoad) pc_d = PCIn;
        if (FetchReq) begin
          start_pc_d = PCLoad ? PCIn : pc_q;
          wait_cnt_d = '0;
          state_d    = FETCH_LO;
        end
      end
      FETCH_LO, FETCH_HI: begin
        MemRead = 1'b1;
        IRWrite = MemValid;
        IRLH    = (state_q == FETCH_HI);
        if (MemValid) begin
          pc_d       = pc_q + ADDR_W'(1);
          wait_cnt_d = '0;
          state_d    = (state_q == FETCH_LO) ? FETCH_HI : DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // Rewind so a retry refetches the whole instruction, not just the missing byte.
          if (wait_cnt_q == WAIT_LAST) begin
            pc_d    = start_pc_q;
            state_d = ERR;
          end
        end
      end
      DONE: begin
        FetchDone = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        FetchErr = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MemAddr = pc_q;
  assign PC      = pc_q;
  assign IRData  = MemData;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Randomized and directed bench for instruction_fetch_sequencer, with a cycle-count reference
// model derived from the fetch rules (TIMEOUT=4 so that the timeout boundary is reachable).
module tb_instruction_fetch_sequencer;
  localparam int TMO = 4;

  logic        Clock = 1'b0;
  logic        Reset, FetchReq, PCLoad, MemValid;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic        MemRead, IRWrite, IRLH, Busy, FetchDone, FetchErr;
  logic [15:0] MemAddr, PC;
  logic [7:0]  IRData;

  instruction_fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .FetchReq(FetchReq), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemData(MemData), .MemValid(MemValid), .MemRead(MemRead), .MemAddr(MemAddr),
    .IRData(IRData), .IRWrite(IRWrite), .IRLH(IRLH), .PC(PC), .Busy(Busy),
    .FetchDone(FetchDone), .FetchErr(FetchErr)
  );

  always #5 Clock = ~Clock;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] mem [0:65535];
  logic [15:0] pc_model;

  // observations of one fetch
  int r_done_cyc, r_err_cyc, r_done_cnt, r_err_cnt, r_wr_cnt, r_unstable;
  logic [15:0] r_ir, r_addr_lo, r_addr_hi, r_final_pc;
  logic busy_log [0:23];

  // model expectations
  int e_done_cyc, e_err_cyc;
  logic [15:0] e_ir, e_pc, e_start;

  task automatic model(input logic do_load, input logic [15:0] pc_in, input int lw, input int hw);
    logic [15:0] s1;
    e_start = do_load ? pc_in : pc_model;
    s1 = e_start + 16'd1;
    e_ir = {mem[s1], mem[e_start]};
    e_done_cyc = -1;
    e_err_cyc = -1;
    if (lw >= TMO) begin
      e_err_cyc = 1 + TMO;
      e_pc = e_start;
    end else if (hw >= TMO) begin
      e_err_cyc = lw + 2 + TMO;
      e_pc = e_start;
    end else begin
      e_done_cyc = lw + hw + 3;
      e_pc = e_start + 16'd2;
    end
    pc_model = e_pc;
  endtask

  // Drives one fetch and a reactive memory for 20 cycles; cycle 0 carries FetchReq.
  task automatic run_fetch(input logic do_load, input logic [15:0] pc_in, input int lw,
                           input int hw, input int inj_cyc, input int rst_cyc);
    int phase, cnt;
    logic [15:0] ph_addr;
    r_done_cyc = -1; r_err_cyc = -1; r_done_cnt = 0; r_err_cnt = 0;
    r_wr_cnt = 0; r_unstable = 0; r_ir = 16'hxxxx; r_addr_lo = 16'hxxxx; r_addr_hi = 16'hxxxx;
    phase = 0; cnt = 0; ph_addr = '0;
    @(negedge Clock);
    Reset = 1'b1; FetchReq = 1'b1; PCLoad = do_load; PCIn = pc_in; MemValid = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(negedge Clock);
      FetchReq = 1'b0; PCLoad = 1'b0;
      Reset = (c == rst_cyc) ? 1'b0 : 1'b1;
      if (c == inj_cyc) begin
        FetchReq = 1'b1; PCLoad = 1'b1; PCIn = 16'hBEEF;
      end
      MemValid = (phase < 2) && (cnt == ((phase == 0) ? lw : hw));
      MemData = mem[MemAddr];
      #1;
      busy_log[c] = Busy;
      if (MemRead) begin
        if (cnt == 0) ph_addr = MemAddr;
        else if (MemAddr !== ph_addr) r_unstable++;
      end
      if (IRWrite) begin
        r_wr_cnt++;
        if (IRLH) begin r_ir[15:8] = IRData; r_addr_hi = MemAddr; end
        else begin r_ir[7:0] = IRData; r_addr_lo = MemAddr; end
      end
      if (FetchDone) begin r_done_cnt++; if (r_done_cyc < 0) r_done_cyc = c; end
      if (FetchErr) begin r_err_cnt++; if (r_err_cyc < 0) r_err_cyc = c; end
      if (MemValid) begin phase++; cnt = 0; end
      else if (phase < 2) cnt++;
      if (c == rst_cyc) phase = 2;
    end
    @(negedge Clock);
    MemValid = 1'b0; Reset = 1'b1;
    #1 r_final_pc = PC;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Reset = 1'b0; FetchReq = 1'b0; PCLoad = 1'b0; PCIn = '0; MemValid = 1'b0; MemData = '0;
    @(negedge Clock);
    @(negedge Clock);
    #1;
    tests_run++;
    if ({Busy, MemRead, IRWrite, FetchDone, FetchErr} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b want 00000", {Busy, MemRead, IRWrite, FetchDone, FetchErr});
    end
    tests_run++;
    if (PC !== 16'h0000 || MemAddr !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_pc: got PC=%h addr=%h want 0000", PC, MemAddr);
    end
    Reset = 1'b1;
    pc_model = 16'h0000;
  endtask

  task automatic test_basic();
    mem[0] = 8'h34; mem[1] = 8'h12;
    model(1'b0, 16'h0, 0, 0);
    run_fetch(1'b0, 16'h0, 0, 0, -1, -1);
    tests_run++;
    if (r_ir !== 16'h1234) begin tests_failed++; $display("FAIL basic_ir: got %h want 1234", r_ir); end
    tests_run++;
    if (r_done_cyc !== 3 || r_done_cnt !== 1) begin
      tests_failed++; $display("FAIL basic_done: got cyc %0d cnt %0d want 3/1", r_done_cyc, r_done_cnt);
    end
    tests_run++;
    if (r_final_pc !== 16'h0002) begin tests_failed++; $display("FAIL basic_pc: got %h want 0002", r_final_pc); end
    tests_run++;
    if (busy_log[1] !== 1'b1 || busy_log[3] !== 1'b1 || busy_log[4] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_busy: got %b%b%b want 110", busy_log[1], busy_log[3], busy_log[4]);
    end
  endtask

  task automatic test_load_and_fetch();
    mem[16'h00FF] = 8'hCD; mem[16'h0100] = 8'hAB;
    model(1'b1, 16'h00FF, 0, 0);
    run_fetch(1'b1, 16'h00FF, 0, 0, -1, -1);
    tests_run++;
    if (r_addr_lo !== 16'h00FF || r_addr_hi !== 16'h0100) begin
      tests_failed++; $display("FAIL load_addr: got %h/%h want 00ff/0100", r_addr_lo, r_addr_hi);
    end
    tests_run++;
    if (r_ir !== 16'hABCD || r_final_pc !== 16'h0101) begin
      tests_failed++; $display("FAIL load_ir_pc: got ir %h pc %h want abcd/0101", r_ir, r_final_pc);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
    @(negedge Clock);
    PCLoad = 1'b1; PCIn = 16'hFFFF;
    @(negedge Clock);
    PCLoad = 1'b0;
    #1;
    tests_run++;
    if (PC !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_load: got %h want ffff", PC); end
    pc_model = 16'hFFFF;
    model(1'b0, 16'h0, 0, 0);
    run_fetch(1'b0, 16'h0, 0, 0, -1, -1);
    tests_run++;
    if (r_addr_lo !== 16'hFFFF || r_addr_hi !== 16'h0000) begin
      tests_failed++; $display("FAIL wrap_addr: got %h/%h want ffff/0000", r_addr_lo, r_addr_hi);
    end
    tests_run++;
    if (r_ir !== 16'h5678 || r_final_pc !== 16'h0001) begin
      tests_failed++; $display("FAIL wrap_ir_pc: got ir %h pc %h want 5678/0001", r_ir, r_final_pc);
    end
  endtask

  task automatic test_wait_states();
    model(1'b1, 16'h0300, 3, 3);
    run_fetch(1'b1, 16'h0300, 3, 3, -1, -1);
    tests_run++;
    if (r_done_cyc !== 9) begin tests_failed++; $display("FAIL wait_done: got %0d want 9", r_done_cyc); end
    tests_run++;
    if (r_wr_cnt !== 2 || r_unstable !== 0) begin
      tests_failed++; $display("FAIL wait_writes: got wr %0d unstable %0d want 2/0", r_wr_cnt, r_unstable);
    end
    tests_run++;
    if (r_ir !== e_ir || r_final_pc !== e_pc) begin
      tests_failed++; $display("FAIL wait_ir_pc: got %h/%h want %h/%h", r_ir, r_final_pc, e_ir, e_pc);
    end
  endtask

  task automatic test_timeout_retry();
    model(1'b1, 16'h0200, 0, 9);
    run_fetch(1'b1, 16'h0200, 0, 9, -1, -1);
    tests_run++;
    if (r_err_cyc !== e_err_cyc || r_err_cnt !== 1 || r_done_cnt !== 0) begin
      tests_failed++; $display("FAIL tmo_err: got cyc %0d err %0d done %0d want %0d/1/0", r_err_cyc, r_err_cnt, r_done_cnt, e_err_cyc);
    end
    tests_run++;
    if (r_final_pc !== 16'h0200) begin tests_failed++; $display("FAIL tmo_pc: got %h want 0200", r_final_pc); end
    model(1'b0, 16'h0, 0, 0);
    run_fetch(1'b0, 16'h0, 0, 0, -1, -1);
    tests_run++;
    if (r_done_cyc !== 3 || r_ir !== e_ir || r_final_pc !== 16'h0202) begin
      tests_failed++; $display("FAIL tmo_retry: got cyc %0d ir %h pc %h want 3/%h/0202", r_done_cyc, r_ir, r_final_pc, e_ir);
    end
  endtask

  task automatic test_reset_mid_fetch();
    run_fetch(1'b1, 16'h0400, 0, 9, -1, 2);
    pc_model = 16'h0000;
    tests_run++;
    if (r_done_cnt !== 0 || r_err_cnt !== 0) begin
      tests_failed++; $display("FAIL rstmid_pulse: got done %0d err %0d want 0/0", r_done_cnt, r_err_cnt);
    end
    tests_run++;
    if (busy_log[3] !== 1'b0 || r_final_pc !== 16'h0000) begin
      tests_failed++; $display("FAIL rstmid_idle: got busy %b pc %h want 0/0000", busy_log[3], r_final_pc);
    end
  endtask

  task automatic test_ignore_during_fetch();
    model(1'b0, 16'h0, 2, 1);
    run_fetch(1'b0, 16'h0, 2, 1, 1, -1);
    tests_run++;
    if (r_done_cyc !== e_done_cyc || r_done_cnt !== 1 || r_final_pc !== e_pc) begin
      tests_failed++; $display("FAIL ignore: got cyc %0d cnt %0d pc %h want %0d/1/%h", r_done_cyc, r_done_cnt, r_final_pc, e_done_cyc, e_pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic ld;
      logic [15:0] tgt;
      int lw, hw;
      ld  = 1'($urandom);
      tgt = 16'($urandom);
      lw  = $urandom_range(0, 5);
      hw  = $urandom_range(0, 5);
      model(ld, tgt, lw, hw);
      run_fetch(ld, tgt, lw, hw, -1, -1);
      tests_run++;
      if (r_done_cyc !== e_done_cyc || r_err_cyc !== e_err_cyc || r_final_pc !== e_pc
          || (e_done_cyc > 0 && r_ir !== e_ir)) begin
        tests_failed++;
        $display("FAIL rand%0d: got done %0d err %0d pc %h ir %h want %0d/%0d/%h/%h", n,
                 r_done_cyc, r_err_cyc, r_final_pc, r_ir, e_done_cyc, e_err_cyc, e_pc, e_ir);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    Reset = 1'b0; FetchReq = 1'b0; PCLoad = 1'b0; PCIn = '0; MemValid = 1'b0; MemData = '0;
    pc_model = '0;
    test_reset();
    test_basic();
    test_load_and_fetch();
    test_wrap();
    test_wait_states();
    test_timeout_retry();
    test_reset_mid_fetch();
    test_ignore_during_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
